// File: rtl/io_cfg_pkg.sv
// -----------------------------------------------------------------------------
// io_cfg_pkg
// Shared definitions for the I/O configuration loader: FSM state codes, the
// frame sync byte, the layout of a pad configuration entry and TSMUX codes.
// No ports (package).
// -----------------------------------------------------------------------------
package io_cfg_pkg;

  // Frame delimiter expected as the first byte of every frame
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // FSM state codes (plain constants so older tools can share them)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_COUNT  = 3'd2;
  localparam logic [2:0] ST_ADDR   = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_CSUM   = 3'd5;
  localparam logic [2:0] ST_COMMIT = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  // Field positions inside a CFG byte; bits [7:3] carry no meaning
  localparam int CFG_TSMUX_LSB  = 0;
  localparam int CFG_TSMUX_MSB  = 1;
  localparam int CFG_DORREG_BIT = 2;
  localparam int CFG_W          = 3;

  // TSMUX encodings seen by a pad
  typedef enum logic [1:0] {
    TSMUX_TRISTATE = 2'b00,
    TSMUX_TS_GATED = 2'b01,
    TSMUX_DRIVE    = 2'b10,
    TSMUX_DRIVE_B  = 2'b11
  } tsmux_e;

  // One pad's configuration, packed in CFG-byte order {DORREG, TSMUX[1:0]}
  typedef struct packed {
    logic       dorreg;
    logic [1:0] tsmux;
  } pad_cfg_t;

endpackage

// File: rtl/io_cfg_shadow.sv
// -----------------------------------------------------------------------------
// io_cfg_shadow
// Shadow and active register banks, NUM_IO entries of 3 bits each. The shadow
// bank collects a frame's writes; commit copies the whole shadow bank into the
// active bank in one edge, so the pads never see a half-written frame.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_load            shadow <= active (start of a new frame)
//   i_wr_en/addr/data indexed write into the shadow bank
//   i_commit          active <= shadow for every pad
//   o_tsmux, o_dorreg active configuration driven to the pads
// -----------------------------------------------------------------------------
module io_cfg_shadow
  import io_cfg_pkg::*;
#(
  parameter int NUM_IO = 44,
  parameter int ADDR_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  pad_cfg_t              i_wr_data,
  input  logic                  i_commit,
  output logic [2*NUM_IO-1:0]   o_tsmux,
  output logic [NUM_IO-1:0]     o_dorreg
);

  pad_cfg_t r_shadow [NUM_IO];
  pad_cfg_t r_active [NUM_IO];

  // Shadow/active bank update: load, indexed write, atomic commit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_IO; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (i_load) begin
          r_shadow[i] <= r_active[i];
        end else if (i_wr_en && (i_wr_addr == ADDR_W'(i))) begin
          r_shadow[i] <= i_wr_data;
        end else begin
          r_shadow[i] <= r_shadow[i];
        end
        if (i_commit) begin
          r_active[i] <= r_shadow[i];
        end else begin
          r_active[i] <= r_active[i];
        end
      end
    end
  end

  // Flatten the active bank onto the pad buses
  always_comb begin
    o_tsmux  = '0;
    o_dorreg = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      o_tsmux[2*i +: 2] = r_active[i].tsmux;
      o_dorreg[i]       = r_active[i].dorreg;
    end
  end

endmodule

// File: rtl/io_cfg_loader.sv
// -----------------------------------------------------------------------------
// io_cfg_loader
// Receives a framed byte stream (SYNC, COUNT, COUNT x {ADDR, CFG}) over a
// valid/ready port and configures TSMUX/DORREG of NUM_IO pads. Writes go to a
// shadow bank and are committed atomically only if the whole frame validates;
// a bad frame parks the FSM in ERROR and leaves the pads untouched.
// Optional build macro IOCFG_CHECKSUM_EN: adds a trailing checksum byte that
// must equal the XOR of COUNT and all ADDR/CFG bytes.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_start              one-cycle pulse, begins a frame from IDLE/ERROR
//   i_cfg_data/valid     byte stream input
//   o_cfg_ready          loader accepts a byte this cycle
//   o_busy               frame in progress (SYNC..COMMIT)
//   o_done               one-cycle pulse during COMMIT
//   o_err                sticky frame error, cleared by i_start
//   o_tsmux, o_dorreg    per-pad configuration outputs
// -----------------------------------------------------------------------------
module io_cfg_loader
  import io_cfg_pkg::*;
#(
  parameter int NUM_IO = 44,
  parameter int ADDR_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_cfg_data,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [2*NUM_IO-1:0]   o_tsmux,
  output logic [NUM_IO-1:0]     o_dorreg
);

  localparam logic [7:0] NUM_IO_B = 8'(NUM_IO);

  logic [2:0]        r_state;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
`ifdef IOCFG_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic [2:0]        w_next;
  logic              w_xfer;
  logic              w_load;
  logic              w_wr_en;
  logic              w_commit;
  pad_cfg_t          w_cfg;

  assign w_xfer   = i_cfg_valid & r_ready;
  assign w_load   = i_start & ((r_state == ST_IDLE) | (r_state == ST_ERROR));
  assign w_wr_en  = w_xfer & (r_state == ST_DATA);
  assign w_commit = (r_state == ST_COMMIT);
  assign w_cfg    = pad_cfg_t'(i_cfg_data[CFG_W-1:0]);

  // Next-state logic; every byte-consuming state waits for a transfer
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_ERROR: begin
        if (i_start) begin
          w_next = ST_SYNC;
        end else begin
          w_next = r_state;
        end
      end
      ST_SYNC: begin
        if (w_xfer) begin
          w_next = (i_cfg_data == SYNC_BYTE) ? ST_COUNT : ST_ERROR;
        end else begin
          w_next = ST_SYNC;
        end
      end
      ST_COUNT: begin
        if (w_xfer) begin
          if ((i_cfg_data == 8'd0) || (i_cfg_data > NUM_IO_B)) begin
            w_next = ST_ERROR;
          end else begin
            w_next = ST_ADDR;
          end
        end else begin
          w_next = ST_COUNT;
        end
      end
      ST_ADDR: begin
        if (w_xfer) begin
          w_next = (i_cfg_data >= NUM_IO_B) ? ST_ERROR : ST_DATA;
        end else begin
          w_next = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (w_xfer) begin
          // r_cnt still holds the pre-decrement value: 1 means this is the last entry
          if (r_cnt == 8'd1) begin
`ifdef IOCFG_CHECKSUM_EN
            w_next = ST_CSUM;
`else
            w_next = ST_COMMIT;
`endif
          end else begin
            w_next = ST_ADDR;
          end
        end else begin
          w_next = ST_DATA;
        end
      end
`ifdef IOCFG_CHECKSUM_EN
      ST_CSUM: begin
        if (w_xfer) begin
          w_next = (i_cfg_data == r_csum) ? ST_COMMIT : ST_ERROR;
        end else begin
          w_next = ST_CSUM;
        end
      end
`endif
      ST_COMMIT: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, entry counter and latched pad address
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_xfer && (r_state == ST_COUNT)) begin
        r_cnt <= i_cfg_data;
      end else if (w_wr_en) begin
        r_cnt <= r_cnt - 8'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_xfer && (r_state == ST_ADDR)) begin
        r_addr <= i_cfg_data[ADDR_W-1:0];
      end else begin
        r_addr <= r_addr;
      end
    end
  end

`ifdef IOCFG_CHECKSUM_EN
  // Running XOR over COUNT and every ADDR/CFG byte of the frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_csum <= 8'd0;
    end else if (w_xfer && (r_state == ST_COUNT)) begin
      r_csum <= i_cfg_data;
    end else if (w_xfer && ((r_state == ST_ADDR) || (r_state == ST_DATA))) begin
      r_csum <= r_csum ^ i_cfg_data;
    end else begin
      r_csum <= r_csum;
    end
  end
`endif

  // Status outputs registered from the next state so they align with r_state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= (w_next inside {ST_SYNC, ST_COUNT, ST_ADDR, ST_DATA, ST_CSUM});
      r_busy  <= (w_next inside {ST_SYNC, ST_COUNT, ST_ADDR, ST_DATA, ST_CSUM, ST_COMMIT});
      r_done  <= (w_next == ST_COMMIT);
      r_err   <= (w_next == ST_ERROR);
    end
  end

  assign o_cfg_ready = r_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

  io_cfg_shadow #(
    .NUM_IO (NUM_IO),
    .ADDR_W (ADDR_W)
  ) u_shadow (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_addr),
    .i_wr_data (w_cfg),
    .i_commit  (w_commit),
    .o_tsmux   (o_tsmux),
    .o_dorreg  (o_dorreg)
  );

endmodule

// File: tb/tb_io_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_io_cfg_loader
// Scoreboard bench for io_cfg_loader. Each frame is evaluated by a byte-level
// reference parser that keeps the pad configuration as a plain array; the
// expected outcome (commit or error, plus resulting pad outputs) is queued and
// a monitor pops it when the DUT pulses DONE or raises ERR.
// -----------------------------------------------------------------------------
module tb_io_cfg_loader;

  localparam int NUM_IO = 44;
  localparam int ADDR_W = 6;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit                  is_err;
    logic [2*NUM_IO-1:0] ts;
    logic [NUM_IO-1:0]   dr;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [7:0]          data;
  logic                valid;
  logic                ready;
  logic                busy;
  logic                done;
  logic                err;
  logic [2*NUM_IO-1:0] ts;
  logic [NUM_IO-1:0]   dr;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [2:0] model_cfg [NUM_IO];

  always #5 clk = ~clk;

  io_cfg_loader #(.NUM_IO(NUM_IO), .ADDR_W(ADDR_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_cfg_data  (data),
    .i_cfg_valid (valid),
    .o_cfg_ready (ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_tsmux     (ts),
    .o_dorreg    (dr)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_pack(output logic [2*NUM_IO-1:0] t, output logic [NUM_IO-1:0] d);
    for (int i = 0; i < NUM_IO; i++) begin
      t[2*i +: 2] = model_cfg[i][1:0];
      d[i]        = model_cfg[i][2];
    end
  endtask

  // Build a frame from a flat list of {addr, cfg} bytes
  function automatic bq_t mk_frame(input bq_t ent);
    bq_t q;
    logic [7:0] x;
    x = 8'(ent.size() / 2);
    q.push_back(8'hA5);
    q.push_back(x);
    foreach (ent[i]) begin
      q.push_back(ent[i]);
      x = x ^ ent[i];
    end
`ifdef IOCFG_CHECKSUM_EN
    q.push_back(x);
`endif
    return q;
  endfunction

  // Monitor: pops the scoreboard on DONE pulses and on ERR rising
  initial begin : monitor
    bit prev_err;
    exp_t e;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_err = 1'b0;
      end else if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 128'd1, 128'd0);
        end else begin
          e = sb.pop_front();
          chk("done_kind", 128'(e.is_err), 128'd0);
          @(negedge clk);
          chk("done_one_cycle", 128'(done), 128'd0);
          chk("commit_tsmux", 128'(ts), 128'(e.ts));
          chk("commit_dorreg", 128'(dr), 128'(e.dr));
        end
        prev_err = err;
      end else begin
        if (err && !prev_err) begin
          if (sb.size() == 0) begin
            chk("unexpected_err", 128'd1, 128'd0);
          end else begin
            e = sb.pop_front();
            chk("err_kind", 128'(e.is_err), 128'd1);
            chk("err_tsmux_kept", 128'(ts), 128'(e.ts));
            chk("err_dorreg_kept", 128'(dr), 128'(e.dr));
          end
        end
        prev_err = err;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        valid = 1'b0;
        data  = 8'($urandom);
      end
    end
    @(negedge clk);
    valid = 1'b1;
    data  = b;
    t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 128'd0, 128'd1);
  endtask

  // Evaluate frame against the reference rules, queue the outcome, drive it
  task automatic run_frame(input bq_t fr, input bit gaps);
    logic [2:0] tmp [NUM_IO];
    bit   ok;
    int   used;
    int   n;
    int   t;
    logic [7:0] x;
    exp_t e;
    tmp  = model_cfg;
    ok   = 1'b1;
    used = fr.size();
    if (fr[0] != 8'hA5) begin
      ok = 1'b0; used = 1;
    end else begin
      n = int'(fr[1]);
      if (n == 0 || n > NUM_IO) begin
        ok = 1'b0; used = 2;
      end else begin
        x = fr[1];
        for (int k = 0; k < n && ok; k++) begin
          if (int'(fr[2+2*k]) >= NUM_IO) begin
            ok = 1'b0; used = 3 + 2*k;
          end else begin
            tmp[fr[2+2*k]] = fr[3+2*k][2:0];
            x = x ^ fr[2+2*k] ^ fr[3+2*k];
          end
        end
`ifdef IOCFG_CHECKSUM_EN
        if (ok && fr[2+2*n] != x) begin
          ok = 1'b0; used = 3 + 2*n;
        end
`endif
      end
    end
    if (ok) model_cfg = tmp;
    e.is_err = !ok;
    model_pack(e.ts, e.dr);
    sb.push_back(e);

    pulse_start();
    chk("start_clears_err", 128'(err), 128'd0);
    for (int i = 0; i < used; i++) send_byte(fr[i], gaps);
    @(negedge clk);
    valid = 1'b0;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", 128'd0, 128'd1);
    if (!ok) begin
      chk("err_ready_low", 128'(ready), 128'd0);
      chk("err_sticky", 128'(err), 128'd1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
  endtask

  initial begin : stim
    bq_t fr;
    bq_t ent;
    int  n;
    int  kind;
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = 8'd0;
    foreach (model_cfg[i]) model_cfg[i] = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tsmux", 128'(ts), 128'd0);
    chk("rst_dorreg", 128'(dr), 128'd0);
    chk("rst_ready", 128'(ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_done", 128'(done), 128'd0);

    // VALID while not ready must not start anything
    valid = 1'b1; data = 8'hA5;
    repeat (3) @(negedge clk);
    chk("idle_ignores_valid", 128'({ready, busy}), 128'd0);
    valid = 1'b0;

    // Directed good frame
    ent = '{8'h05, 8'h07, 8'h2B, 8'h01};
    run_frame(mk_frame(ent), 1'b0);
    drain();
    chk("pad5_tsmux", 128'(ts[11:10]), 128'd3);
    chk("pad5_dorreg", 128'(dr[5]), 128'd1);
    chk("pad43_tsmux", 128'(ts[87:86]), 128'd1);
    chk("pad43_dorreg", 128'(dr[43]), 128'd0);
    chk("pad0_untouched", 128'({dr[0], ts[1:0]}), 128'd0);

    // Bad sync, then a good frame recovers
    fr = '{8'h5A, 8'h01, 8'h00, 8'h03};
    run_frame(fr, 1'b0);
    ent = '{8'h00, 8'h06, 8'h10, 8'h02};
    run_frame(mk_frame(ent), 1'b1);

    // Out-of-range address, COUNT 0, COUNT 45
    ent = '{8'h05, 8'h03, 8'h2C, 8'h01};
    run_frame(mk_frame(ent), 1'b0);
    fr = '{8'hA5, 8'h00};
    run_frame(fr, 1'b0);
    fr = '{8'hA5, 8'h2D};
    run_frame(fr, 1'b0);

    // Same good frame with VALID toggling
    ent = '{8'h05, 8'h07, 8'h2B, 8'h01};
    run_frame(mk_frame(ent), 1'b1);

    // Duplicate address: last write wins
    ent = '{8'h05, 8'h07, 8'h05, 8'h00};
    run_frame(mk_frame(ent), 1'b1);
    drain();
    chk("dup_pad5", 128'({dr[5], ts[11:10]}), 128'd0);

`ifdef IOCFG_CHECKSUM_EN
    ent = '{8'h07, 8'h05};
    fr = mk_frame(ent);
    fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
    run_frame(fr, 1'b0);
`endif

    // Randomized frames, good and corrupted
    for (int f = 0; f < 30; f++) begin
      ent.delete();
      n = $urandom_range(1, NUM_IO);
      for (int k = 0; k < n; k++) begin
        ent.push_back(8'($urandom_range(0, NUM_IO-1)));
        ent.push_back(8'($urandom));
      end
      fr = mk_frame(ent);
      kind = $urandom_range(0, 9);
      case (kind)
        0: fr[0] = 8'hA5 ^ 8'($urandom_range(1, 255));
        1: fr[1] = 8'h00;
        2: fr[1] = 8'($urandom_range(NUM_IO+1, 255));
        3: fr[2 + 2*$urandom_range(0, n-1)] = 8'($urandom_range(NUM_IO, 255));
        4: fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h80;
        default: ;
      endcase
      run_frame(fr, 1'b1);
    end
    drain();

    // Reset in the middle of a frame
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h05, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    #1;
    chk("midrst_tsmux", 128'(ts), 128'd0);
    chk("midrst_dorreg", 128'(dr), 128'd0);
    chk("midrst_ready", 128'(ready), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    foreach (model_cfg[i]) model_cfg[i] = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    ent = '{8'h2A, 8'h05};
    run_frame(mk_frame(ent), 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
